// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter and its bus watchdog.
package sram_arbiter_pkg;

    localparam int unsigned SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INST  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
    function automatic int unsigned wd_count_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/sram_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles without ack and flags expiry at TIMEOUT-1.
module bus_watchdog
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = wd_count_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] count;

    // TIMEOUT of zero disables the watchdog entirely.
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one req/ack SRAM port between instruction fetch and the mem stage.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_valid_o,
    output logic              inst_pause_o,
    input  logic              flush_i,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_sel_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              data_pause_o,

    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic [3:0]        sram_sel_o,
    input  logic              sram_ack_i,
    input  logic [DATA_W-1:0] sram_rdata_i,

    output logic              bus_err_o
);

    arb_state_t state;

    logic busy;
    logic done;
    logic go_drain;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign busy      = (state != ST_IDLE);
    assign done      = busy & (sram_ack_i | wd_expired);
    assign wd_enable = busy & ~sram_ack_i;
    assign go_drain  = (state == ST_INST) & flush_i & ~sram_ack_i & ~wd_expired;
    // Entering DRAIN restarts the count; the abandoned fetch gets a full window.
    assign wd_clear  = ~busy | go_drain;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // A watchdog abort still completes the request, with zero data.
    assign inst_valid_o = (state == ST_INST) & done & ~flush_i;
    assign inst_rdata_o = (inst_valid_o & sram_ack_i) ? sram_rdata_i : '0;
    assign data_valid_o = (state == ST_DATA) & done;
    assign data_rdata_o = (data_valid_o & sram_ack_i & ~sram_we_o) ? sram_rdata_i : '0;

    // Pauses are forced low while reset is asserted so every output reads 0.
    assign inst_pause_o = rst & inst_req_i & ~inst_valid_o & ~flush_i;
    assign data_pause_o = rst & data_req_i & ~data_valid_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            sram_req_o   <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            sram_sel_o   <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            if (wd_expired) begin
                bus_err_o <= 1'b1;
            end

            if (done) begin
                state        <= ST_IDLE;
                sram_req_o   <= 1'b0;
                sram_we_o    <= 1'b0;
                sram_addr_o  <= '0;
                sram_wdata_o <= '0;
                sram_sel_o   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Data wins: the mem-stage instruction is older than the fetch.
                        if (data_req_i) begin
                            state        <= ST_DATA;
                            sram_req_o   <= 1'b1;
                            sram_we_o    <= data_we_i;
                            sram_addr_o  <= data_addr_i;
                            sram_wdata_o <= data_wdata_i;
                            sram_sel_o   <= data_sel_i;
                        end else if (inst_req_i && !flush_i) begin
                            state        <= ST_INST;
                            sram_req_o   <= 1'b1;
                            sram_we_o    <= 1'b0;
                            sram_addr_o  <= inst_addr_i;
                            sram_wdata_o <= '0;
                            sram_sel_o   <= SEL_ALL;
                        end
                    end
                    ST_INST: begin
                        if (flush_i) begin
                            state <= ST_DRAIN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter against a cycle-count reference model.
module tb_sram_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_valid_o;
    logic        inst_pause_o;
    logic        flush_i;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_rdata_o;
    logic        data_valid_o;
    logic        data_pause_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_sel_o;
    logic        sram_ack_i;
    logic [31:0] sram_rdata_i;
    logic        bus_err_o;

    int errors;
    int checks;

    sram_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_rdata_o (inst_rdata_o),
        .inst_valid_o (inst_valid_o),
        .inst_pause_o (inst_pause_o),
        .flush_i      (flush_i),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_sel_i   (data_sel_i),
        .data_rdata_o (data_rdata_o),
        .data_valid_o (data_valid_o),
        .data_pause_o (data_pause_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_sel_o   (sram_sel_o),
        .sram_ack_i   (sram_ack_i),
        .sram_rdata_i (sram_rdata_i),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request; the model: sram_req_o high for cycles 1..lat, completion at lat.
    task automatic do_txn(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int lat, input logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        v;
        logic        p;
        logic [31:0] r;
        exp_rd = (is_data && we) ? 32'h0 : rd;
        if (is_data) begin
            data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
            data_wdata_i = wdata; data_sel_i = sel;
        end else begin
            inst_req_i = 1'b1; inst_addr_i = addr;
        end
        sram_ack_i = 1'b0;
        #1;
        checks++;
        if (sram_req_o !== 1'b0) begin errors++; $display("FAIL txn_idle_req: got %b expected 0", sram_req_o); end
        p = is_data ? data_pause_o : inst_pause_o;
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL txn_idle_pause: got %b expected 1", p); end
        tick();
        for (int c = 1; c <= lat; c++) begin
            sram_ack_i   = (c == lat);
            sram_rdata_i = (c == lat) ? rd : $urandom;
            #1;
            checks++;
            if (sram_req_o !== 1'b1) begin errors++; $display("FAIL txn_req c%0d: got %b expected 1", c, sram_req_o); end
            checks++;
            if (sram_addr_o !== addr) begin errors++; $display("FAIL txn_addr c%0d: got %h expected %h", c, sram_addr_o, addr); end
            checks++;
            if (sram_we_o !== (is_data ? we : 1'b0)) begin errors++; $display("FAIL txn_we c%0d: got %b", c, sram_we_o); end
            checks++;
            if (sram_sel_o !== (is_data ? sel : 4'hF)) begin errors++; $display("FAIL txn_sel c%0d: got %h", c, sram_sel_o); end
            if (is_data) begin
                checks++;
                if (sram_wdata_o !== wdata) begin errors++; $display("FAIL txn_wdata c%0d: got %h expected %h", c, sram_wdata_o, wdata); end
            end
            v = is_data ? data_valid_o : inst_valid_o;
            checks++;
            if (v !== (c == lat)) begin errors++; $display("FAIL txn_valid c%0d: got %b expected %b", c, v, (c == lat)); end
            p = is_data ? data_pause_o : inst_pause_o;
            checks++;
            if (p !== (c != lat)) begin errors++; $display("FAIL txn_pause c%0d: got %b expected %b", c, p, (c != lat)); end
            if (c == lat) begin
                r = is_data ? data_rdata_o : inst_rdata_o;
                checks++;
                if (r !== exp_rd) begin errors++; $display("FAIL txn_rdata: got %h expected %h", r, exp_rd); end
            end
            tick();
        end
        inst_req_i = 1'b0; data_req_i = 1'b0; sram_ack_i = 1'b0;
        #1;
        checks++;
        if (sram_req_o !== 1'b0 || sram_addr_o !== 32'h0) begin
            errors++; $display("FAIL txn_drop: req %b addr %h expected 0/0", sram_req_o, sram_addr_o);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_req_i = 1'b1; data_req_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sram_req_o, sram_we_o, sram_sel_o, bus_err_o} !== 7'h0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {sram_req_o, sram_we_o, sram_sel_o, bus_err_o});
        end
        checks++;
        if ({sram_addr_o, sram_wdata_o} !== 64'h0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {sram_addr_o, sram_wdata_o});
        end
        checks++;
        if ({inst_valid_o, data_valid_o, inst_pause_o, data_pause_o} !== 4'h0) begin
            errors++; $display("FAIL reset_hs: got %b expected 0000", {inst_valid_o, data_valid_o, inst_pause_o, data_pause_o});
        end
        checks++;
        if ({inst_rdata_o, data_rdata_o} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {inst_rdata_o, data_rdata_o});
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        do_txn(1'b0, 1'b0, 32'h1C000000, 32'h0, 4'hF, 3, 32'h02800C0C);
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b0, 1'b0, $urandom & 32'hFFFFFFFC, 32'h0, 4'hF, $urandom_range(1, 5), $urandom);
        end
    endtask

    task automatic test_data_access();
        do_txn(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 4, 32'hA5A5A5A5);
        for (int i = 0; i < 6; i++) begin
            do_txn(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                   $urandom_range(1, 5), $urandom);
        end
    endtask

    // Both requesters at once: data phase, one IDLE gap, then fetch phase.
    task automatic test_priority();
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] rdi;
        logic [31:0] rdd;
        int          ld;
        int          li;
        for (int i = 0; i < 4; i++) begin
            ia = $urandom; da = (i == 0) ? 32'h100 : $urandom;
            rdi = $urandom; rdd = $urandom;
            ld = $urandom_range(1, 4); li = $urandom_range(1, 4);
            inst_req_i = 1'b1; inst_addr_i = ia;
            data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = da; data_sel_i = 4'hF;
            sram_ack_i = 1'b0;
            #1;
            checks++;
            if ({inst_pause_o, data_pause_o} !== 2'b11) begin errors++; $display("FAIL prio_idle_pause: got %b expected 11", {inst_pause_o, data_pause_o}); end
            tick();
            for (int c = 1; c <= ld; c++) begin
                sram_ack_i = (c == ld); sram_rdata_i = (c == ld) ? rdd : $urandom;
                #1;
                checks++;
                if (sram_addr_o !== da) begin errors++; $display("FAIL prio_data_addr: got %h expected %h", sram_addr_o, da); end
                checks++;
                if ({data_valid_o, inst_valid_o, inst_pause_o} !== {1'(c == ld), 1'b0, 1'b1}) begin
                    errors++; $display("FAIL prio_data_phase c%0d: dv/iv/ip got %b", c, {data_valid_o, inst_valid_o, inst_pause_o});
                end
                if (c == ld) begin
                    checks++;
                    if (data_rdata_o !== rdd) begin errors++; $display("FAIL prio_data_rdata: got %h expected %h", data_rdata_o, rdd); end
                end
                tick();
            end
            data_req_i = 1'b0; sram_ack_i = 1'b0;
            #1;
            checks++;
            if ({sram_req_o, inst_pause_o, inst_valid_o} !== 3'b010) begin
                errors++; $display("FAIL prio_gap: req/ip/iv got %b expected 010", {sram_req_o, inst_pause_o, inst_valid_o});
            end
            tick();
            for (int c = 1; c <= li; c++) begin
                sram_ack_i = (c == li); sram_rdata_i = (c == li) ? rdi : $urandom;
                #1;
                checks++;
                if (sram_addr_o !== ia) begin errors++; $display("FAIL prio_inst_addr: got %h expected %h", sram_addr_o, ia); end
                checks++;
                if ({inst_valid_o, inst_pause_o} !== {1'(c == li), 1'(c != li)}) begin
                    errors++; $display("FAIL prio_inst_phase c%0d: iv/ip got %b", c, {inst_valid_o, inst_pause_o});
                end
                if (c == li) begin
                    checks++;
                    if (inst_rdata_o !== rdi) begin errors++; $display("FAIL prio_inst_rdata: got %h expected %h", inst_rdata_o, rdi); end
                end
                tick();
            end
            inst_req_i = 1'b0; sram_ack_i = 1'b0;
            #1;
            tick();
        end
    endtask

    // Flush either coincides with the ack (straight to IDLE) or lands before it (drain).
    task automatic test_flush();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        int          k;
        int          m;
        bit          with_ack;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; rd = $urandom;
            k = $urandom_range(1, 3); m = $urandom_range(1, 3);
            with_ack = (i % 2) == 1;
            inst_req_i = 1'b1; inst_addr_i = a; sram_ack_i = 1'b0;
            #1;
            tick();
            for (int c = 1; c <= k; c++) begin
                flush_i = (c == k); sram_ack_i = with_ack && (c == k); sram_rdata_i = $urandom;
                #1;
                checks++;
                if (sram_addr_o !== a || inst_valid_o !== 1'b0) begin
                    errors++; $display("FAIL flush_inst c%0d: addr %h valid %b expected %h/0", c, sram_addr_o, inst_valid_o, a);
                end
                checks++;
                if (inst_pause_o !== (c != k)) begin errors++; $display("FAIL flush_pause c%0d: got %b", c, inst_pause_o); end
                tick();
            end
            flush_i = 1'b0; inst_addr_i = b; sram_ack_i = 1'b0;
            if (!with_ack) begin
                for (int d = 1; d <= m; d++) begin
                    sram_ack_i = (d == m); sram_rdata_i = $urandom;
                    #1;
                    checks++;
                    if ({sram_req_o, inst_valid_o, inst_pause_o} !== 3'b101 || sram_addr_o !== a) begin
                        errors++; $display("FAIL flush_drain d%0d: req/iv/ip %b addr %h", d, {sram_req_o, inst_valid_o, inst_pause_o}, sram_addr_o);
                    end
                    tick();
                end
            end
            sram_ack_i = 1'b0;
            #1;
            checks++;
            if (sram_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
                errors++; $display("FAIL flush_idle: req %b iv %b expected 0/0", sram_req_o, inst_valid_o);
            end
            tick();
            for (int c = 1; c <= 2; c++) begin
                sram_ack_i = (c == 2); sram_rdata_i = rd;
                #1;
                checks++;
                if (sram_addr_o !== b || inst_valid_o !== (c == 2)) begin
                    errors++; $display("FAIL flush_refetch c%0d: addr %h iv %b expected %h", c, sram_addr_o, inst_valid_o, b);
                end
                tick();
            end
            inst_req_i = 1'b0; sram_ack_i = 1'b0;
            #1;
            tick();
        end
    endtask

    task automatic test_timeout();
        int last;
        // Unacked data read: completes with zero after TO busy cycles.
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = $urandom; data_sel_i = 4'hF;
        sram_ack_i = 1'b0; sram_rdata_i = 32'hFFFFFFFF;
        #1;
        tick();
        for (int c = 1; c <= int'(TO); c++) begin
            #1;
            checks++;
            if ({sram_req_o, data_valid_o, bus_err_o} !== {1'b1, 1'(c == int'(TO)), 1'b0}) begin
                errors++; $display("FAIL to_data c%0d: req/dv/err got %b", c, {sram_req_o, data_valid_o, bus_err_o});
            end
            if (c == int'(TO)) begin
                checks++;
                if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL to_data_rdata: got %h expected 0", data_rdata_o); end
            end
            tick();
        end
        data_req_i = 1'b0;
        #1;
        checks++;
        if ({sram_req_o, bus_err_o} !== 2'b01) begin errors++; $display("FAIL to_after: req/err got %b expected 01", {sram_req_o, bus_err_o}); end
        tick();
        sram_ack_i = 1'b1; sram_rdata_i = $urandom;
        #1;
        checks++;
        if ({data_valid_o, inst_valid_o} !== 2'b00) begin errors++; $display("FAIL to_late_ack: dv/iv got %b expected 00", {data_valid_o, inst_valid_o}); end
        tick();
        sram_ack_i = 1'b0;
        #1;
        checks++;
        if ({sram_req_o, bus_err_o} !== 2'b01) begin errors++; $display("FAIL to_sticky: req/err got %b expected 01", {sram_req_o, bus_err_o}); end
        tick();
        // Unacked fetch.
        inst_req_i = 1'b1; inst_addr_i = $urandom;
        #1;
        tick();
        for (int c = 1; c <= int'(TO); c++) begin
            #1;
            checks++;
            if ({sram_req_o, inst_valid_o} !== {1'b1, 1'(c == int'(TO))} ||
                (c == int'(TO) && inst_rdata_o !== 32'h0)) begin
                errors++; $display("FAIL to_inst c%0d: req/iv %b rdata %h", c, {sram_req_o, inst_valid_o}, inst_rdata_o);
            end
            tick();
        end
        inst_req_i = 1'b0;
        #1;
        tick();
        // Fetch flushed in its first cycle; DRAIN gets a fresh TO window, no valid.
        inst_req_i = 1'b1; inst_addr_i = $urandom;
        #1;
        tick();
        last = 1 + int'(TO);
        for (int c = 1; c <= last + 1; c++) begin
            flush_i = (c == 1);
            if (c >= 2) inst_req_i = 1'b0;
            #1;
            checks++;
            if ({sram_req_o, inst_valid_o} !== {1'(c <= last), 1'b0}) begin
                errors++; $display("FAIL to_drain c%0d: req/iv got %b expected %b0", c, {sram_req_o, inst_valid_o}, (c <= last));
            end
            tick();
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = $urandom | 32'h1;
        data_wdata_i = $urandom | 32'h1; data_sel_i = 4'hF; sram_ack_i = 1'b0;
        #1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        sram_ack_i = 1'b1;
        #1;
        checks++;
        if ({sram_req_o, sram_we_o, sram_sel_o, bus_err_o, data_valid_o, data_pause_o} !== 9'h0) begin
            errors++; $display("FAIL rstmid_ctrl: got %b expected 0", {sram_req_o, sram_we_o, sram_sel_o, bus_err_o, data_valid_o, data_pause_o});
        end
        checks++;
        if ({sram_addr_o, sram_wdata_o, data_rdata_o} !== 96'h0) begin
            errors++; $display("FAIL rstmid_bus: got %h expected 0", {sram_addr_o, sram_wdata_o, data_rdata_o});
        end
        data_req_i = 1'b0; sram_ack_i = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        do_txn(1'b1, 1'b0, $urandom, $urandom, 4'hF, 2, $urandom);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b0; inst_req_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
        data_sel_i = '0; sram_ack_i = 1'b0; sram_rdata_i = '0;
        test_reset();
        test_fetch();
        test_data_access();
        test_priority();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
